alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32; datapath width, legal values >= 32.
REQ-002 SHALL have parameter OPW, default 4; opcode width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request strobe; accepted only when busy=0.
REQ-006 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-007 SHALL have port op  input  OPW  operation select, sampled on accept.
REQ-008 SHALL have ports a, b  input  WIDTH  operands, sampled on accept.
REQ-009 SHALL have ports pc  input  WIDTH, and imm  input  WIDTH  branch/jump context, sampled on accept.
REQ-010 SHALL have port busy  output  1  high while a multi-cycle op is in flight.
REQ-011 SHALL have port done  output  1  one-cycle pulse when results are valid.
REQ-012 SHALL have port y  output  WIDTH  primary result, low product, quotient, or next PC.
REQ-013 SHALL have port hi  output  WIDTH  high product or remainder.
REQ-014 SHALL have ports zero, ovf  output  1 each  y==0 flag, and signed ADD/SUB overflow flag.

Function
REQ-015 SHALL use opcodes 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 BEQ, 6 J, 7 SLT, 8 BNE, 9 MULTU, 10 DIVU.
REQ-016 Single-cycle ops (0-8), once accepted, SHALL register y/zero/ovf and pulse done exactly one cycle later; hi is unchanged.
REQ-017 BEQ/BNE SHALL set y = pc+4 + (sign-extended imm[15:0] << 2) when the condition holds, else y = pc+4, with WIDTH-bit wrap-around.
REQ-018 J SHALL set y = {(pc+4)[WIDTH-1:28], imm[25:0], 2'b00}.
REQ-019 SLT SHALL set y to 1 for a<b signed, else 0.
REQ-020 ovf SHALL be valid for ADD/SUB only and 0 for all other ops.
REQ-021 FSM states SHALL be IDLE, MUL, DIV, DONE: IDLE->DONE for single-cycle ops, IDLE->MUL or IDLE->DIV on accept, MUL/DIV->DONE after WIDTH iterations, DONE->IDLE unconditionally.
REQ-022 MULTU SHALL be shift-add, one bit per cycle, with {hi,y} = a*b unsigned and done WIDTH+1 cycles after accept.
REQ-023 DIVU SHALL be restoring, one bit per cycle, with y = a/b and hi = a%b unsigned, and done WIDTH+1 cycles after accept.
REQ-024 DIVU with b==0 SHALL skip iteration, set y = all-ones and hi = a, and pulse done one cycle after accept.
REQ-025 busy SHALL be high in MUL and DIV states only; start while busy=1 SHALL be ignored with no queueing.
REQ-026 flush SHALL force IDLE next cycle with no done pulse, leave y/hi holding their last values, and take priority over start in the same cycle.
REQ-027 Undefined opcodes SHALL set y=0, zero=1, ovf=0, and pulse done after one cycle.
REQ-028 Outputs SHALL hold their values between done pulses.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and busy, done, y, hi, ovf to 0, and zero to 1.
REQ-030 Reset asserted mid-MULTU/DIVU SHALL abort the op, with no done pulse after release.

Configuration
REQ-031 With ALU_DIV_EN defined, DIVU and the DIV state SHALL be built.
REQ-032 With ALU_DIV_EN undefined, opcode 10 SHALL be treated as undefined per REQ-027 and no divider logic SHALL exist.

Structure
REQ-033 Opcode localparams, the FSM state enum and OPW SHALL live in shared package alu_pkg.
REQ-034 The iterative multiplier/divider datapath SHALL be one sub-module, alu_muldiv_iter, with its own start/busy/done signals, instantiated once.

Verification
REQ-035 ADD a=32'h7FFFFFFF, b=1 -> one cycle later y=32'h80000000, ovf=1, zero=0, done pulse.
REQ-036 BEQ a=b=5, pc=32'h00400000, imm=16'hFFFF -> y=32'h00400000; same with a=5, b=6 -> y=32'h00400004.
REQ-037 MULTU a=32'hFFFFFFFF, b=2 -> after 33 cycles hi=1, y=32'hFFFFFFFE; start pulses while busy ignored.
REQ-038 DIVU a=100, b=7 -> after 33 cycles y=14, hi=2; DIVU b=0 -> after 1 cycle y=32'hFFFFFFFF, hi=100.
REQ-039 Start MULTU, assert flush at cycle 10 -> IDLE next cycle, busy=0, no done; new ADD accepted afterwards.
REQ-040 Assert rst_n=0 mid-DIVU -> outputs cleared asynchronously; no done after release; repeat with ALU_DIV_EN undefined -> DIVU gives y=0, done after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and default opcode width for alu_multicycle.
// Opcode 10 (DIVU) only has an implementation when ALU_DIV_EN is defined.
package alu_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] OP_AND   = 4'd0;
  localparam logic [OPW-1:0] OP_OR    = 4'd1;
  localparam logic [OPW-1:0] OP_ADD   = 4'd2;
  localparam logic [OPW-1:0] OP_SUB   = 4'd3;
  localparam logic [OPW-1:0] OP_XOR   = 4'd4;
  localparam logic [OPW-1:0] OP_BEQ   = 4'd5;
  localparam logic [OPW-1:0] OP_J     = 4'd6;
  localparam logic [OPW-1:0] OP_SLT   = 4'd7;
  localparam logic [OPW-1:0] OP_BNE   = 4'd8;
  localparam logic [OPW-1:0] OP_MULTU = 4'd9;
  localparam logic [OPW-1:0] OP_DIVU  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial unsigned shift-add multiplier and (with ALU_DIV_EN) restoring divider.
// lo/hi present the value after the current iteration so the caller can capture it on the last one.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
`ifdef ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             run_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] lo_next_s;
  logic [WIDTH-1:0] hi_next_s;
`ifdef ALU_DIV_EN
  logic             div_r;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;
`endif

  // One iteration step: {hi,lo} holds partial product / remainder and quotient.
  always_comb begin
    mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    lo_next_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    hi_next_s = mul_sum_s[WIDTH:1];
`ifdef ALU_DIV_EN
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    if (div_r) begin
      // Borrow out of the trial subtraction means restore the shifted remainder.
      lo_next_s = {lo_r[WIDTH-2:0], ~div_diff_s[WIDTH]};
      hi_next_s = div_diff_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
    end else begin
      lo_next_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
`endif
  end

  assign busy = run_r;
  assign done = run_r && (cnt_r == CNT_W'(WIDTH-1));
  assign lo   = lo_next_s;
  assign hi   = hi_next_s;

  // Operand load, iteration counter and working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
      lo_r  <= {WIDTH{1'b0}};
      hi_r  <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
`ifdef ALU_DIV_EN
      div_r <= 1'b0;
`endif
    end else if (flush) begin
      run_r <= 1'b0;
    end else if (start) begin
      run_r <= 1'b1;
      cnt_r <= {CNT_W{1'b0}};
      lo_r  <= a;
      hi_r  <= {WIDTH{1'b0}};
      b_r   <= b;
`ifdef ALU_DIV_EN
      div_r <= is_div;
`endif
    end else if (run_r) begin
      lo_r  <= lo_next_s;
      hi_r  <= hi_next_s;
      cnt_r <= cnt_r + CNT_W'(1);
      run_r <= ~done;
    end else begin
      run_r <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/branch ops plus iterative MULTU and DIVU.
// DIVU and the DIV state are only built when ALU_DIV_EN is defined; otherwise opcode 10 is undefined.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int OPW   = alu_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf
);
  import alu_pkg::*;

  state_t           state_r;
  state_t           state_next_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] hi_r;
  logic             zero_r;
  logic             ovf_r;

  logic [WIDTH-1:0] pc4_s;
  logic [WIDTH-1:0] br_off_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] alu_y_s;
  logic             alu_ovf_s;
  logic [WIDTH-1:0] res_y_s;
  logic [WIDTH-1:0] res_hi_s;
  logic             res_hi_en_s;
  logic             res_ovf_s;

  logic             iter_start_s;
  logic             iter_busy_s;
  logic             iter_done_s;
  logic [WIDTH-1:0] iter_lo_s;
  logic [WIDTH-1:0] iter_hi_s;
`ifdef ALU_DIV_EN
  logic             iter_div_s;
`endif
  logic             unused_s;

  assign unused_s = ^{imm[WIDTH-1:26], iter_busy_s};

  assign pc4_s    = pc + WIDTH'(32'd4);
  assign br_off_s = {{(WIDTH-18){imm[15]}}, imm[15:0], 2'b00};
  assign sum_s    = a + b;
  assign diff_s   = a - b;

  // Single-cycle result and signed overflow; undefined opcodes give zero.
  always_comb begin
    alu_y_s   = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    case (op)
      OPW'(OP_AND): alu_y_s = a & b;
      OPW'(OP_OR):  alu_y_s = a | b;
      OPW'(OP_XOR): alu_y_s = a ^ b;
      OPW'(OP_ADD): begin
        alu_y_s   = sum_s;
        alu_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OPW'(OP_SUB): begin
        alu_y_s   = diff_s;
        alu_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OPW'(OP_BEQ): alu_y_s = (a == b) ? (pc4_s + br_off_s) : pc4_s;
      OPW'(OP_BNE): alu_y_s = (a != b) ? (pc4_s + br_off_s) : pc4_s;
      OPW'(OP_J):   alu_y_s = {pc4_s[WIDTH-1:28], imm[25:0], 2'b00};
      OPW'(OP_SLT): alu_y_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: begin
        alu_y_s   = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
      end
    endcase
  end

  // Next-state logic; flush wins over start and over iterator completion.
  always_comb begin
    state_next_s = state_r;
    iter_start_s = 1'b0;
`ifdef ALU_DIV_EN
    iter_div_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else if (start) begin
          if (op == OPW'(OP_MULTU)) begin
            state_next_s = ST_MUL;
            iter_start_s = 1'b1;
          end
`ifdef ALU_DIV_EN
          else if ((op == OPW'(OP_DIVU)) && (b != {WIDTH{1'b0}})) begin
            state_next_s = ST_DIV;
            iter_start_s = 1'b1;
            iter_div_s   = 1'b1;
          end
`endif
          else begin
            state_next_s = ST_DONE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else if (iter_done_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Value captured on entry to DONE: iterator result, divide-by-zero, or single-cycle result.
  always_comb begin
    res_y_s     = alu_y_s;
    res_hi_s    = hi_r;
    res_hi_en_s = 1'b0;
    res_ovf_s   = alu_ovf_s;
    if (state_r != ST_IDLE) begin
      res_y_s     = iter_lo_s;
      res_hi_s    = iter_hi_s;
      res_hi_en_s = 1'b1;
      res_ovf_s   = 1'b0;
    end
`ifdef ALU_DIV_EN
    else if (op == OPW'(OP_DIVU)) begin
      res_y_s     = {WIDTH{1'b1}};
      res_hi_s    = a;
      res_hi_en_s = 1'b1;
      res_ovf_s   = 1'b0;
    end
`endif
    else begin
      res_y_s     = alu_y_s;
      res_hi_en_s = 1'b0;
      res_ovf_s   = alu_ovf_s;
    end
  end

  // State register and registered outputs; results only change when DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      y_r     <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      zero_r  <= 1'b1;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_MUL) || (state_next_s == ST_DIV);
      done_r  <= (state_next_s == ST_DONE);
      if (state_next_s == ST_DONE) begin
        y_r    <= res_y_s;
        zero_r <= (res_y_s == {WIDTH{1'b0}});
        ovf_r  <= res_ovf_s;
        if (res_hi_en_s) begin
          hi_r <= res_hi_s;
        end
      end
    end
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start_s),
    .flush  (flush),
`ifdef ALU_DIV_EN
    .is_div (iter_div_s),
`endif
    .a      (a),
    .b      (b),
    .busy   (iter_busy_s),
    .done   (iter_done_s),
    .lo     (iter_lo_s),
    .hi     (iter_hi_s)
  );

  assign busy = busy_r;
  assign done = done_r;
  assign y    = y_r;
  assign hi   = hi_r;
  assign zero = zero_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases plus random ops against an arithmetic model.
// Expectations for opcode 10 follow ALU_DIV_EN.
module tb_alu_multicycle;

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [3:0]  op;
  logic [31:0] a, b, pc, imm;
  logic        busy, done, zero, ovf;
  logic [31:0] y, hi;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_y;
  logic [31:0] m_hi;

  alu_multicycle #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .pc(pc), .imm(imm), .busy(busy), .done(done),
    .y(y), .hi(hi), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: result from plain arithmetic; updates model y/hi state.
  task automatic model(input logic [3:0] o, input logic [31:0] ia, ib, ipc, iimm,
                       output logic eovf, output int lat);
    longint s;
    longint t;
    logic [63:0] p;
    eovf = 1'b0;
    lat  = 1;
    case (o)
      4'd0: m_y = ia & ib;
      4'd1: m_y = ia | ib;
      4'd4: m_y = ia ^ ib;
      4'd2, 4'd3: begin
        if (o == 4'd2) s = longint'($signed(ia)) + longint'($signed(ib));
        else           s = longint'($signed(ia)) - longint'($signed(ib));
        m_y  = s[31:0];
        eovf = (s > MAXI) || (s < MINI);
      end
      4'd5, 4'd8: begin
        t = longint'(ipc) + 64'sd4;
        if ((o == 4'd5) == (ia == ib)) t = t + longint'($signed(iimm[15:0])) * 64'sd4;
        m_y = t[31:0];
      end
      4'd6: m_y = ((ipc + 32'd4) & 32'hF000_0000) | ((iimm & 32'h03FF_FFFF) << 2);
      4'd7: m_y = ($signed(ia) < $signed(ib)) ? 32'd1 : 32'd0;
      4'd9: begin
        p    = 64'(ia) * 64'(ib);
        m_y  = p[31:0];
        m_hi = p[63:32];
        lat  = 33;
      end
`ifdef ALU_DIV_EN
      4'd10: begin
        if (ib == 32'd0) begin
          m_y  = 32'hFFFF_FFFF;
          m_hi = ia;
        end else begin
          m_y  = ia / ib;
          m_hi = ia % ib;
          lat  = 33;
        end
      end
`endif
      default: m_y = 32'd0;
    endcase
  endtask

  // Issue one op, optionally poke start while busy, and check the completed result.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] ia, ib, ipc, iimm,
                        input bit noise);
    logic eovf;
    int   elat;
    int   lat;
    model(o, ia, ib, ipc, iimm, eovf, elat);
    @(negedge clk);
    start = 1'b1; op = o; a = ia; b = ib; pc = ipc; imm = iimm;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, elat > 1});
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (noise && lat >= 3 && lat <= 6) begin
        start = 1'b1; op = 4'd2; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, ".lat"}, lat, elat);
    check({tag, ".y"}, y, m_y);
    check({tag, ".hi"}, hi, m_hi);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, m_y == 32'd0});
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eovf});
    @(negedge clk);
    check({tag, ".pulse"}, {31'd0, done}, 32'd0);
  endtask

  // Count done pulses over a window in which none is allowed.
  task automatic no_done(input string tag, input int cycles);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    check(tag, n, 0);
  endtask

  initial begin
    logic [3:0] rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 4'd0;
    a = 32'd0; b = 32'd0; pc = 32'd0; imm = 32'd0;
    m_y = 32'd0; m_hi = 32'd0;
    repeat (2) @(negedge clk);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.y", y, 32'd0);
    check("rst.hi", hi, 32'd0);
    check("rst.zero", {31'd0, zero}, 32'd1);
    check("rst.ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;

    run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);
    run_op("sub_ovf", 4'd3, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 1'b0);
    run_op("beq_t", 4'd5, 32'd5, 32'd5, 32'h0040_0000, 32'h0000_FFFF, 1'b0);
    run_op("beq_nt", 4'd5, 32'd5, 32'd6, 32'h0040_0000, 32'h0000_FFFF, 1'b0);
    run_op("bne_t", 4'd8, 32'd5, 32'd6, 32'hFFFF_FFF8, 32'h0000_0010, 1'b0);
    run_op("j", 4'd6, 32'd0, 32'd0, 32'hA000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("slt", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);
    run_op("multu", 4'd9, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1'b1);
    run_op("divu", 4'd10, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
    run_op("divu0", 4'd10, 32'd100, 32'd0, 32'd0, 32'd0, 1'b0);
    run_op("undef", 4'd13, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0);

    // Flush in the middle of a multiply: no done, outputs hold.
    @(negedge clk);
    start = 1'b1; op = 4'd9; a = 32'd12345; b = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush.busy", {31'd0, busy}, 32'd0);
    check("flush.done", {31'd0, done}, 32'd0);
    no_done("flush.nodone", 40);
    check("flush.y", y, m_y);
    check("flush.hi", hi, m_hi);
    run_op("after_flush", 4'd2, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0);

    // Flush and start in the same cycle: flush wins.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 4'd2; a = 32'd10; b = 32'd20;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    no_done("flushstart.nodone", 5);
    check("flushstart.y", y, m_y);

    // Asynchronous reset in the middle of an iterative op.
    @(negedge clk);
`ifdef ALU_DIV_EN
    start = 1'b1; op = 4'd10; a = 32'd100; b = 32'd7;
`else
    start = 1'b1; op = 4'd9; a = 32'd100; b = 32'd7;
`endif
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.busy", {31'd0, busy}, 32'd0);
    check("arst.done", {31'd0, done}, 32'd0);
    check("arst.y", y, 32'd0);
    check("arst.hi", hi, 32'd0);
    check("arst.zero", {31'd0, zero}, 32'd1);
    check("arst.ovf", {31'd0, ovf}, 32'd0);
    m_y = 32'd0; m_hi = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    no_done("arst.nodone", 40);

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = 32'd0;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb, $urandom & 32'hFFFF_FFFC, $urandom, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
